// File: rtl/wb_slave_mem_pkg.sv
// Shared types and defaults for the Wishbone slave memory.
// Out-of-window error termination is enabled by WB_SLAVE_MEM_ERR_EN.
package wb_slave_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } wb_mem_state_e;

    localparam int          DEF_ADDR_W      = 32;
    localparam int          DEF_DATA_W      = 32;
    localparam int          DEF_DEPTH       = 256;
    localparam logic [31:0] DEF_BASE_ADDR   = 32'h0000_0000;
    localparam int          DEF_WAIT_STATES = 1;

    function automatic logic byte_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/wb_slave_mem_if.sv
// Wishbone B3 classic bus bundle between interconnect and slave memory.
// Signal names follow the Wishbone slave-side convention.
interface wb_slave_mem_if
    import wb_slave_mem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic                  CYC_I;
    logic                  STB_I;
    logic                  WE_I;
    logic [ADDR_W-1:0]     ADR_I;
    logic [DATA_W-1:0]     DAT_I;
    logic [DATA_W/8-1:0]   SEL_I;
    logic                  LOCK_I;
    logic                  TGA_I;
    logic                  TGC_I;
    logic [DATA_W-1:0]     DAT_O;
    logic [DATA_W/8-1:0]   TGD_O;
    logic                  ACK_O;
    logic                  ERR_O;
    logic                  RTY_O;

    modport slave (
        input  CYC_I, STB_I, WE_I, ADR_I, DAT_I, SEL_I,
        input  LOCK_I, TGA_I, TGC_I,
        output DAT_O, TGD_O, ACK_O, ERR_O, RTY_O
    );

    modport master (
        output CYC_I, STB_I, WE_I, ADR_I, DAT_I, SEL_I,
        output LOCK_I, TGA_I, TGC_I,
        input  DAT_O, TGD_O, ACK_O, ERR_O, RTY_O
    );
endinterface

// File: rtl/wb_slave_mem_ram.sv
// Single-port synchronous RAM with byte write enables.
// Read data is registered one edge after the enabled read.
module wb_slave_mem_ram
    import wb_slave_mem_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic                     clk_i,
    input  logic                     en_i,
    input  logic                     we_i,
    input  logic [DATA_W/8-1:0]      be_i,
    input  logic [$clog2(DEPTH)-1:0] addr_i,
    input  logic [DATA_W-1:0]        wdata_i,
    output logic [DATA_W-1:0]        rdata_o
);
    localparam int BW = DATA_W / 8;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) begin
                for (int b = 0; b < BW; b++) begin
                    if (be_i[b]) begin
                        mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                    end
                end
            end else begin
                rdata_q <= mem_q[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/wb_slave_mem.sv
// Wishbone B3 classic slave memory with programmable wait states.
// Define WB_SLAVE_MEM_ERR_EN to answer out-of-window accesses with ERR_O.
module wb_slave_mem
    import wb_slave_mem_pkg::*;
#(
    parameter int               ADDR_W      = DEF_ADDR_W,
    parameter int               DATA_W      = DEF_DATA_W,
    parameter int               DEPTH       = DEF_DEPTH,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = ADDR_W'(DEF_BASE_ADDR),
    parameter int               WAIT_STATES = DEF_WAIT_STATES
) (
    input logic           CLK_I,
    input logic           RST_I,
    wb_slave_mem_if.slave wb
);
    localparam int BW    = DATA_W / 8;
    localparam int OFF_W = $clog2(BW);
    localparam int IDX_W = $clog2(DEPTH);

    wb_mem_state_e state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              ack_q, ack_d;
    logic              err_q, err_d;
    logic              rd_q, rd_d;
    logic              we_q, hit_q;
    logic [IDX_W-1:0]  idx_q;
    logic [DATA_W-1:0] dat_q;
    logic [BW-1:0]     sel_q;

    logic              req, latch, commit, hit;
    logic [ADDR_W-1:0] off, word;
    logic [DATA_W-1:0] rdata, dat_o;
    logic [BW-1:0]     tgd;

    assign req  = wb.CYC_I & wb.STB_I;
    assign off  = wb.ADR_I - BASE_ADDR;
    assign word = off >> OFF_W;

`ifdef WB_SLAVE_MEM_ERR_EN
    assign hit = (wb.ADR_I >= BASE_ADDR) && (word < ADDR_W'(DEPTH));
`else
    // Upper index bits are dropped, so the window aliases modulo DEPTH.
    assign hit = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        latch   = 1'b0;
        commit  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    latch   = 1'b1;
                    cnt_d   = 4'(WAIT_STATES);
                    state_d = (WAIT_STATES == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (!req) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                commit  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        ack_d = commit & hit_q;
        err_d = commit & ~hit_q;
        rd_d  = commit & hit_q & ~we_q;
    end

    always_ff @(posedge CLK_I) begin
        if (!RST_I) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rd_q    <= rd_d;
        end
    end

    always_ff @(posedge CLK_I) begin
        if (latch) begin
            we_q  <= wb.WE_I;
            hit_q <= hit;
            idx_q <= word[IDX_W-1:0];
            dat_q <= wb.DAT_I;
            sel_q <= wb.SEL_I;
        end
    end

    wb_slave_mem_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk_i   (CLK_I),
        .en_i    (commit & hit_q & RST_I),
        .we_i    (we_q),
        .be_i    (sel_q),
        .addr_i  (idx_q),
        .wdata_i (dat_q),
        .rdata_o (rdata)
    );

    assign dat_o = rd_q ? rdata : '0;

    always_comb begin
        tgd = '0;
        for (int b = 0; b < BW; b++) begin
            tgd[b] = ack_q & byte_parity(dat_o[8*b +: 8]);
        end
    end

    assign wb.DAT_O = dat_o;
    assign wb.TGD_O = tgd;
    assign wb.ACK_O = ack_q;
    assign wb.ERR_O = err_q;
    assign wb.RTY_O = 1'b0;

    logic unused_ok;
    assign unused_ok = ^{wb.LOCK_I, wb.TGA_I, wb.TGC_I, word};
endmodule

// File: tb/tb_wb_slave_mem.sv
// Directed bench for wb_slave_mem: DUT A with one wait state, DUT B with three.
// Expectations for the 0x400 access follow WB_SLAVE_MEM_ERR_EN.
module tb_wb_slave_mem;
    import wb_slave_mem_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   ncomp = 0;
    int   nfail = 0;

    always #5 clk = ~clk;

    wb_slave_mem_if #(.ADDR_W(32), .DATA_W(32)) if_a ();
    wb_slave_mem_if #(.ADDR_W(32), .DATA_W(32)) if_b ();

    wb_slave_mem #(
        .ADDR_W(32), .DATA_W(32), .DEPTH(256),
        .BASE_ADDR(32'h0), .WAIT_STATES(1)
    ) dut_a (
        .CLK_I (clk),
        .RST_I (rst_n),
        .wb    (if_a)
    );

    wb_slave_mem #(
        .ADDR_W(32), .DATA_W(32), .DEPTH(256),
        .BASE_ADDR(32'h0), .WAIT_STATES(3)
    ) dut_b (
        .CLK_I (clk),
        .RST_I (rst_n),
        .wb    (if_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        ncomp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int d, input logic cs, input logic we,
                         input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel);
        if (d == 0) begin
            if_a.CYC_I = cs; if_a.STB_I = cs; if_a.WE_I = we;
            if_a.ADR_I = adr; if_a.DAT_I = dat; if_a.SEL_I = sel;
        end else begin
            if_b.CYC_I = cs; if_b.STB_I = cs; if_b.WE_I = we;
            if_b.ADR_I = adr; if_b.DAT_I = dat; if_b.SEL_I = sel;
        end
    endtask

    task automatic smp(input int d, output logic a, output logic e,
                       output logic r, output logic [31:0] dq,
                       output logic [3:0] t);
        if (d == 0) begin
            a = if_a.ACK_O; e = if_a.ERR_O; r = if_a.RTY_O;
            dq = if_a.DAT_O; t = if_a.TGD_O;
        end else begin
            a = if_b.ACK_O; e = if_b.ERR_O; r = if_b.RTY_O;
            dq = if_b.DAT_O; t = if_b.TGD_O;
        end
    endtask

    // One full transfer; lat counts sampled cycles from the request edge.
    task automatic xfer(input int d, input logic we, input logic [31:0] adr,
                        input logic [31:0] dat, input logic [3:0] sel,
                        output logic [31:0] rdat, output logic [3:0] tgd,
                        output logic ack, output logic err, output int lat);
        logic a, e, r;
        logic [31:0] dq;
        logic [3:0] t;
        drive(d, 1'b1, we, adr, dat, sel);
        lat = 0; ack = 1'b0; err = 1'b0; rdat = 'x; tgd = 'x;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            lat++;
            smp(d, a, e, r, dq, t);
            if (a || e) begin
                ack = a; err = e; rdat = dq; tgd = t;
                break;
            end
        end
        drive(d, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(posedge clk); #1;
        smp(d, a, e, r, dq, t);
        chk("resp_one_cycle", 32'({a, e}), 32'd0);
    endtask

    logic [31:0] rd;
    logic [3:0]  tg;
    logic        ak, er, a, e, r;
    logic [31:0] dq, d0, d1;
    logic [3:0]  t;
    int          lat, first, second;
    logic        prev, consec, seen;

    initial begin
        if_a.LOCK_I = 1'b0; if_a.TGA_I = 1'b0; if_a.TGC_I = 1'b0;
        if_b.LOCK_I = 1'b0; if_b.TGA_I = 1'b0; if_b.TGC_I = 1'b0;
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive(0, 1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF);

        // Reset held for three edges with a request pending
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            smp(0, a, e, r, dq, t);
            chk("rst_ack_err_rty", 32'({a, e, r}), 32'd0);
        end
        chk("rst_dat", dq, 32'h0);
        chk("rst_tgd", 32'(t), 32'd0);
        rst_n = 1'b1;

        xfer(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, rd, tg, ak, er, lat);
        chk("w1_lat", 32'(lat), 32'd3);
        chk("w1_ack", 32'({ak, er}), 32'd2);
        chk("w1_dat", rd, 32'h0);

        xfer(0, 1'b0, 32'h10, 32'h0, 4'hF, rd, tg, ak, er, lat);
        chk("r1_lat", 32'(lat), 32'd3);
        chk("r1_ack", 32'({ak, er}), 32'd2);
        chk("r1_dat", rd, 32'hDEAD_BEEF);
        chk("r1_tgd", 32'(tg), 32'd5);

        xfer(0, 1'b1, 32'h10, 32'h0000_00AA, 4'b0001, rd, tg, ak, er, lat);
        xfer(0, 1'b0, 32'h13, 32'h0, 4'h1, rd, tg, ak, er, lat);
        chk("byte_wr_dat", rd, 32'hDEAD_BEAA);
        chk("byte_wr_tgd", 32'(tg), 32'd4);

        xfer(0, 1'b1, 32'h10, 32'hFFFF_FFFF, 4'h0, rd, tg, ak, er, lat);
        chk("sel0_ack", 32'({ak, er}), 32'd2);
        xfer(0, 1'b0, 32'h10, 32'h0, 4'hF, rd, tg, ak, er, lat);
        chk("sel0_nochange", rd, 32'hDEAD_BEAA);

        xfer(0, 1'b1, 32'h0, 32'hCAFE_F00D, 4'hF, rd, tg, ak, er, lat);
        xfer(0, 1'b1, 32'h4, 32'h0BAD_F00D, 4'hF, rd, tg, ak, er, lat);

        xfer(0, 1'b0, 32'h400, 32'h0, 4'hF, rd, tg, ak, er, lat);
        chk("oow_lat", 32'(lat), 32'd3);
`ifdef WB_SLAVE_MEM_ERR_EN
        chk("oow_err", 32'({ak, er}), 32'd1);
        chk("oow_dat", rd, 32'h0);
        chk("oow_tgd", 32'(tg), 32'd0);
`else
        chk("alias_ack", 32'({ak, er}), 32'd2);
        chk("alias_dat", rd, 32'hCAFE_F00D);
`endif

        // Back-to-back reads with STB held between them
        drive(0, 1'b1, 1'b0, 32'h0, 32'h0, 4'hF);
        first = -1; second = -1; prev = 1'b0; consec = 1'b0;
        d0 = 'x; d1 = 'x;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            smp(0, a, e, r, dq, t);
            if (a && prev) consec = 1'b1;
            if (a) begin
                if (first < 0) begin
                    first = i; d0 = dq;
                    drive(0, 1'b1, 1'b0, 32'h4, 32'h0, 4'hF);
                end else if (second < 0) begin
                    second = i; d1 = dq;
                    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
                end
            end
            prev = a;
        end
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        chk("b2b_first", 32'(first), 32'd2);
        chk("b2b_spacing", 32'(second - first), 32'd3);
        chk("b2b_no_consec", 32'(consec), 32'd0);
        chk("b2b_d0", d0, 32'hCAFE_F00D);
        chk("b2b_d1", d1, 32'h0BAD_F00D);

        // Three wait states, then an aborted write
        xfer(1, 1'b1, 32'h20, 32'h1234_5678, 4'hF, rd, tg, ak, er, lat);
        chk("w3_lat", 32'(lat), 32'd5);
        chk("w3_ack", 32'({ak, er}), 32'd2);

        drive(1, 1'b1, 1'b1, 32'h20, 32'hFFFF_FFFF, 4'hF);
        @(posedge clk); #1;
        @(posedge clk); #1;
        if_b.STB_I = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            smp(1, a, e, r, dq, t);
            if (a || e) seen = 1'b1;
        end
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        chk("abort_no_resp", 32'(seen), 32'd0);

        xfer(1, 1'b0, 32'h20, 32'h0, 4'hF, rd, tg, ak, er, lat);
        chk("abort_lat", 32'(lat), 32'd5);
        chk("abort_dat", rd, 32'h1234_5678);
        chk("abort_tgd", 32'(tg), 32'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
        $finish;
    end
endmodule
